// File: rtl/instr_predecode_queue_pkg.sv
// Shared instruction encoding types and the predecode record carried by the fetch-to-decode queue.
package instr_predecode_queue_pkg;

  typedef enum logic [6:0] {
    OP_NONE   = 7'h00,
    OP_LD     = 7'h03,
    OP_BRR    = 7'h0B,
    OP_ARITHI = 7'h13,
    OP_LDUIPC = 7'h17,
    OP_ST     = 7'h23,
    OP_ARITH  = 7'h33,
    OP_LDUI   = 7'h37,
    OP_BR     = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } op_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_U,
    FMT_CI,
    FMT_CU
  } fmt_t;

  typedef logic [4:0] reg_t;
  typedef logic [4:0] cond_t;
  typedef logic [2:0] funct3_t;

  typedef struct packed {
    op_t         op;
    fmt_t        fmt;
    reg_t        rd;
    reg_t        rs1;
    reg_t        rs2;
    cond_t       cond;
    funct3_t     funct3;
    logic [31:0] imm;
    logic        writes_rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        illegal;
  } predec_t;

  localparam int unsigned PREDEC_W = $bits(predec_t);

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] sext20(input logic [19:0] v);
    return {{12{v[19]}}, v};
  endfunction

endpackage

// File: rtl/instr_predecode_queue_predecode.sv
// Combinational predecoder: raw 32-bit instruction word to predec_t record.
module instr_predecode
  import instr_predecode_queue_pkg::*;
(
  input  logic [31:0] raw,
  output predec_t     pd
);

  op_t  op_v;
  fmt_t fmt_v;
  logic legal;

  // Stage 1: classify opcode and check funct3 legality.
  always_comb begin
    op_v  = OP_NONE;
    fmt_v = FMT_R;
    legal = 1'b1;
    case (raw[31:25])
      OP_ARITH:  begin op_v = OP_ARITH;  fmt_v = FMT_R;  end
      OP_ARITHI: begin op_v = OP_ARITHI; fmt_v = FMT_I;  end
      OP_JALR:   begin op_v = OP_JALR;   fmt_v = FMT_I;  end
      OP_LD: begin
        op_v  = OP_LD;
        fmt_v = FMT_I;
        legal = !(raw[19:17] == 3'b011 || raw[19:17] == 3'b110 || raw[19:17] == 3'b111);
      end
      OP_ST: begin
        op_v  = OP_ST;
        fmt_v = FMT_S;
        legal = (raw[19:17] <= 3'b010);
      end
      OP_LDUI:   begin op_v = OP_LDUI;   fmt_v = FMT_U;  end
      OP_LDUIPC: begin op_v = OP_LDUIPC; fmt_v = FMT_U;  end
      OP_JAL:    begin op_v = OP_JAL;    fmt_v = FMT_U;  end
      OP_BR:     begin op_v = OP_BR;     fmt_v = FMT_CU; end
      OP_BRR:    begin op_v = OP_BRR;    fmt_v = FMT_CI; end
      default:   legal = 1'b0;
    endcase
  end

  // Stage 2: extract fields by format; an illegal word leaves everything but the flag zero.
  always_comb begin
    pd = '0;
    if (!legal) begin
      pd.illegal = 1'b1;
    end else begin
      pd.op  = op_v;
      pd.fmt = fmt_v;
      case (fmt_v)
        FMT_R: begin
          pd.rd        = raw[24:20];
          pd.rs1       = raw[16:12];
          pd.rs2       = raw[11:7];
          pd.funct3    = raw[19:17];
          pd.writes_rd = 1'b1;
          pd.uses_rs1  = 1'b1;
          pd.uses_rs2  = 1'b1;
        end
        FMT_I: begin
          pd.rd        = raw[24:20];
          pd.rs1       = raw[16:12];
          pd.funct3    = raw[19:17];
          pd.imm       = sext12(raw[11:0]);
          pd.writes_rd = 1'b1;
          pd.uses_rs1  = 1'b1;
        end
        FMT_S: begin
          pd.rs1      = raw[16:12];
          pd.rs2      = raw[11:7];
          pd.funct3   = raw[19:17];
          pd.imm      = sext12({raw[6:0], raw[24:20]});
          pd.uses_rs1 = 1'b1;
          pd.uses_rs2 = 1'b1;
        end
        FMT_U: begin
          pd.rd        = raw[24:20];
          pd.imm       = (op_v == OP_JAL) ? sext20(raw[19:0]) : {raw[19:0], 12'b0};
          pd.writes_rd = 1'b1;
        end
        FMT_CI: begin
          pd.cond     = raw[24:20];
          pd.rs1      = raw[16:12];
          pd.funct3   = raw[19:17];
          pd.imm      = sext12(raw[11:0]);
          pd.uses_rs1 = 1'b1;
        end
        FMT_CU: begin
          pd.cond = raw[24:20];
          pd.imm  = sext20(raw[19:0]);
        end
        default: pd.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_predecode_queue.sv
// Fetch-to-decode circular buffer; words are predecoded on entry and the head is presented from flops.
module instr_predecode_queue
  import instr_predecode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_raw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_raw,
  output predec_t         out_pd
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     raw;
    predec_t         pd;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  predec_t       in_pd;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nx, rd_ptr_nx;
  logic          do_push, do_pop;
  logic          full_nx, empty_nx;

  instr_predecode u_predecode (
    .raw (in_raw),
    .pd  (in_pd)
  );

  assign do_push = in_valid && in_ready && !flush;
  assign do_pop  = out_valid && out_ready;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
    end else begin
      if (do_push) wr_ptr_nx = wr_ptr + 1'b1;
      if (do_pop)  rd_ptr_nx = rd_ptr + 1'b1;
    end
  end

  assign full_nx  = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                    (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
  assign empty_nx = (wr_ptr_nx == rd_ptr_nx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      in_ready  <= !full_nx;
      out_valid <= !empty_nx;
    end
  end

  // Payload storage is deliberately left unreset; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, raw: in_raw, pd: in_pd};
  end

  assign head    = mem[rd_ptr[AW-1:0]];
  assign out_pc  = head.pc;
  assign out_raw = head.raw;
  assign out_pd  = head.pd;

endmodule

// File: tb/tb_instr_predecode_queue.sv
// Directed bench for instr_predecode_queue: predecode vector table plus queue-behaviour sequences.
module tb_instr_predecode_queue;
  import instr_predecode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [31:0]     in_raw, out_raw;
  predec_t         out_pd;

  int n_vec = 0;
  int n_mis = 0;

  instr_predecode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_raw    (in_raw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_raw   (out_raw),
    .out_pd    (out_pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] pc;
    predec_t     exp;
  } vec_t;

  vec_t vecs [12];

  function automatic predec_t mk(input op_t op, input fmt_t fmt, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] cond, input logic [2:0] f3,
                                 input logic [31:0] imm, input logic wr, input logic u1,
                                 input logic u2, input logic ill);
    predec_t p;
    p.op = op; p.fmt = fmt; p.rd = rd; p.rs1 = rs1; p.rs2 = rs2; p.cond = cond;
    p.funct3 = f3; p.imm = imm; p.writes_rd = wr; p.uses_rs1 = u1; p.uses_rs2 = u2;
    p.illegal = ill;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h26301FFF, 32'h100, mk(OP_ARITHI, FMT_I, 5'd3, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 1, 1, 0, 0)};
    vecs[1]  = '{32'h6E512345, 32'h104, mk(OP_LDUI, FMT_U, 5'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'h12345000, 1, 0, 0, 0)};
    vecs[2]  = '{32'hFE000000, 32'h108, mk(OP_NONE, FMT_R, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 0, 0, 0, 1)};
    vecs[3]  = '{32'h66749520, 32'h10C, mk(OP_ARITH, FMT_R, 5'd7, 5'd9, 5'd10, 5'd0, 3'd2, 32'h0, 1, 1, 1, 0)};
    vecs[4]  = '{32'h46144340, 32'h110, mk(OP_ST, FMT_S, 5'd0, 5'd4, 5'd6, 5'd0, 3'd2, 32'hFFFFF801, 0, 1, 1, 0)};
    vecs[5]  = '{32'h46060000, 32'h114, mk(OP_NONE, FMT_R, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 0, 0, 0, 1)};
    vecs[6]  = '{32'h06060000, 32'h118, mk(OP_NONE, FMT_R, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 0, 0, 0, 1)};
    vecs[7]  = '{32'hC6280000, 32'h11C, mk(OP_BR, FMT_CU, 5'd0, 5'd0, 5'd0, 5'd2, 3'd0, 32'hFFF80000, 0, 0, 0, 0)};
    vecs[8]  = '{32'hDE100010, 32'h120, mk(OP_JAL, FMT_U, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000010, 1, 0, 0, 0)};
    vecs[9]  = '{32'h16325800, 32'h124, mk(OP_BRR, FMT_CI, 5'd0, 5'd5, 5'd0, 5'd3, 3'd1, 32'hFFFFF800, 0, 1, 0, 0)};
    vecs[10] = '{32'h2E2FFFFF, 32'h128, mk(OP_LDUIPC, FMT_U, 5'd2, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFF000, 1, 0, 0, 0)};
    vecs[11] = '{32'h068437FF, 32'h12C, mk(OP_LD, FMT_I, 5'd8, 5'd3, 5'd0, 5'd0, 3'd2, 32'h000007FF, 1, 1, 0, 0)};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_raw = '0;

    // Reset state
    step(); step();
    check("rst_in_ready_low", in_ready, 0);
    check("rst_out_valid_low", out_valid, 0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // Predecode table: one word at a time, visible one cycle after push
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_raw = vecs[i].raw; in_pc = vecs[i].pc;
      check($sformatf("v%0d_pre_valid", i), out_valid, 0);
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      check($sformatf("v%0d_raw", i), out_raw, vecs[i].raw);
      check($sformatf("v%0d_pd", i), out_pd, vecs[i].exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("v%0d_popped", i), out_valid, 0);
    end

    // Fill to DEPTH with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_raw = 32'hA5000000 | 32'(i);
      step();
    end
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    in_pc = 32'h10;
    step(); step();
    check("held_in_ready", in_ready, 0);
    check("held_out_pc", out_pc, 32'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_pc", i), out_pc, 32'(i * 4));
      step();
      if (i == 0) check("drain_in_ready", in_ready, 1);
    end
    check("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // Steady push+pop across pointer wrap with three entries resident
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i); in_raw = 32'hB0000000 | in_pc;
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_pc = 32'h1000 + 32'(4 * (i + 3)); in_raw = 32'hB0000000 | in_pc;
      check($sformatf("ss%0d_valid", i), out_valid, 1);
      check($sformatf("ss%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("ss%0d_raw", i), out_raw, 32'hB0001000 + 32'(4 * i));
      check($sformatf("ss%0d_in_ready", i), in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ss_tail%0d_pc", i), out_pc, 32'h1000 + 32'(4 * (12 + i)));
      step();
    end
    check("ss_empty", out_valid, 0);
    out_ready = 1'b0;

    // Flush with a concurrent push: the push is dropped
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i);
      step();
    end
    flush = 1'b1; in_pc = 32'h300;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    in_valid = 1'b1; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("post_flush_valid", out_valid, 1);
    check("post_flush_pc", out_pc, 32'h400);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_flush_empty", out_valid, 0);

    // Reset mid-stream with two entries queued
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
